ctrl_regfile: RTL and testbench

- Parametrised AXI4-Lite control/status register file; next generation of the chess-engine PS-to-PL control slave.
- Replaces fixed hand-decoded cases with a generic block: RW_REGS writable registers, RO_REGS read-only status words, and self-clearing pulse bits.
- Full AXI4-Lite handshakes on all five channels, SLVERR for unmapped addresses, and per-register write/read strobes toward the move generator and evaluator.

---
 rtl/vchess_ctrl_pkg.sv | 45 ++++
 rtl/axi4lite_wr_capture.sv | 68 ++++++
 rtl/ctrl_regfile.sv | 154 +++++++++++++++
 tb/tb_ctrl_regfile.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vchess_ctrl_pkg.sv
// Shared constants, register map and bus payload types for the chess-engine
// PS-to-PL control register file.
package vchess_ctrl_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned DEFAULT_RW_REGS = 16;
    localparam int unsigned DEFAULT_RO_REGS = 64;
    localparam int unsigned DEFAULT_RO_BASE = 128;

    // RW register word indices
    localparam int unsigned REG_CTRL       = 0;
    localparam int unsigned REG_MOVE_INDEX = 1;
    localparam int unsigned REG_SIDE_STATE = 2;
    localparam int unsigned REG_BOARD0     = 3;
    localparam int unsigned REG_BOARD1     = 4;
    localparam int unsigned REG_BOARD2     = 5;
    localparam int unsigned REG_BOARD3     = 6;
    localparam int unsigned REG_BOARD4     = 7;
    localparam int unsigned REG_BOARD5     = 8;
    localparam int unsigned REG_BOARD6     = 9;
    localparam int unsigned REG_BOARD7     = 10;

    // Status word offsets relative to RO_BASE
    localparam int unsigned STAT_STATUS    = 0;
    localparam int unsigned STAT_BEST_MOVE = 1;
    localparam int unsigned STAT_EVAL      = 2;
    localparam int unsigned STAT_NODES     = 3;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_beat_t;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int k = 0; k < 4; k++)
            res[8*k +: 8] = strb[k] ? new_val[8*k +: 8] : old_val[8*k +: 8];
        return res;
    endfunction

endpackage

// File: rtl/axi4lite_wr_capture.sv
// AXI4-Lite write-side capture: independent AW/W holding registers, one-cycle
// commit request toward the register file, and the B response handshake.
module axi4lite_wr_capture
    import vchess_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 40
) (
    input  logic                  clk,
    input  logic                  aresetb,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic                  wr_err_c,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output wr_beat_t              wr_beat,
    output logic                  wr_valid_c
);

    logic aw_held;
    logic w_held;

    // Commit as soon as both halves of the write are held
    assign wr_valid_c = aw_held & w_held;

    always_ff @(posedge clk or negedge aresetb) begin
        if (!aresetb) begin
            awready <= 1'b1;
            wready  <= 1'b1;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            wr_addr <= '0;
            wr_beat <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            if (awvalid && awready) begin
                wr_addr <= awaddr;
                aw_held <= 1'b1;
                awready <= 1'b0;
            end
            if (wvalid && wready) begin
                wr_beat <= '{data: wdata, strb: wstrb};
                w_held  <= 1'b1;
                wready  <= 1'b0;
            end
            if (wr_valid_c) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_err_c ? RESP_SLVERR : RESP_OKAY;
            end
            // Ready returns only after the response is consumed: one write in flight
            if (bvalid && bready) begin
                bvalid  <= 1'b0;
                awready <= 1'b1;
                wready  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ctrl_regfile.sv
// Parametrised AXI4-Lite control/status register file for the chess-engine PL.
// Define CTRL_REGFILE_WSTRB_EN to honour wstrb byte lanes on RW register writes.
module ctrl_regfile
    import vchess_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 40,
    parameter int unsigned RW_REGS    = DEFAULT_RW_REGS,
    parameter int unsigned RO_REGS    = DEFAULT_RO_REGS,
    parameter int unsigned RO_BASE    = DEFAULT_RO_BASE,
    parameter logic [31:0] PULSE_MASK = 32'h0000_0007
) (
    input  logic                    clk,
    input  logic                    aresetb,
    input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [2:0]              axi_awprot,
    input  logic                    axi_awvalid,
    output logic                    axi_awready,
    input  logic [31:0]             axi_wdata,
    input  logic [3:0]              axi_wstrb,
    input  logic                    axi_wvalid,
    output logic                    axi_wready,
    output logic [1:0]              axi_bresp,
    output logic                    axi_bvalid,
    input  logic                    axi_bready,
    input  logic [ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [2:0]              axi_arprot,
    input  logic                    axi_arvalid,
    output logic                    axi_arready,
    output logic [31:0]             axi_rdata,
    output logic [1:0]              axi_rresp,
    output logic                    axi_rvalid,
    input  logic                    axi_rready,
    output logic [RW_REGS*32-1:0]   rw_regs,
    output logic [RW_REGS-1:0]      rw_wr_strobe,
    input  logic [RO_REGS*32-1:0]   ro_regs,
    output logic [RO_REGS-1:0]      ro_rd_strobe
);

    localparam int unsigned IW = ADDR_WIDTH - 2;

    logic [31:0]           rw_q [RW_REGS];
    logic [ADDR_WIDTH-1:0] wr_addr;
    wr_beat_t              wr_beat;
    logic                  wr_valid_c;
    logic                  wr_err_c;
    logic [RW_REGS-1:0]    wr_sel_c;
    logic [IW-1:0]         wr_idx;
    logic [IW-1:0]         rd_idx;
    logic [31:0]           rd_data_c;
    logic [1:0]            rd_resp_c;
    logic [RO_REGS-1:0]    rd_ro_sel_c;
    logic                  pulse_clr;
    logic                  unused_c;

    assign unused_c = ^{axi_awprot, axi_arprot, axi_araddr[1:0], wr_addr[1:0], wr_beat.strb};

    axi4lite_wr_capture #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_capture (
        .clk        (clk),
        .aresetb    (aresetb),
        .awaddr     (axi_awaddr),
        .awvalid    (axi_awvalid),
        .awready    (axi_awready),
        .wdata      (axi_wdata),
        .wstrb      (axi_wstrb),
        .wvalid     (axi_wvalid),
        .wready     (axi_wready),
        .bresp      (axi_bresp),
        .bvalid     (axi_bvalid),
        .bready     (axi_bready),
        .wr_err_c   (wr_err_c),
        .wr_addr    (wr_addr),
        .wr_beat    (wr_beat),
        .wr_valid_c (wr_valid_c)
    );

    assign wr_idx = wr_addr[ADDR_WIDTH-1:2];
    assign rd_idx = axi_araddr[ADDR_WIDTH-1:2];

    // Write decode: anything outside the RW window (including RO space) is SLVERR
    always_comb begin
        wr_sel_c = '0;
        for (int unsigned i = 0; i < RW_REGS; i++)
            if (wr_idx == IW'(i)) wr_sel_c[i] = 1'b1;
    end

    assign wr_err_c = ~|wr_sel_c;

    always_ff @(posedge clk or negedge aresetb) begin
        if (!aresetb) begin
            for (int unsigned i = 0; i < RW_REGS; i++) rw_q[i] <= '0;
            rw_wr_strobe <= '0;
            pulse_clr    <= 1'b0;
        end else begin
            pulse_clr    <= wr_valid_c & wr_sel_c[0];
            rw_wr_strobe <= wr_valid_c ? wr_sel_c : '0;
            if (pulse_clr) rw_q[0] <= rw_q[0] & ~PULSE_MASK;
            for (int unsigned i = 0; i < RW_REGS; i++) begin
                if (wr_valid_c && wr_sel_c[i]) begin
`ifdef CTRL_REGFILE_WSTRB_EN
                    rw_q[i] <= strb_merge(rw_q[i], wr_beat.data, wr_beat.strb);
`else
                    rw_q[i] <= wr_beat.data;
`endif
                end
            end
        end
    end

    for (genvar i = 0; i < RW_REGS; i++) begin : g_rw_out
        assign rw_regs[32*i +: 32] = rw_q[i];
    end

    // Read decode sees pre-commit register contents, so a same-cycle commit is not visible
    always_comb begin
        rd_data_c   = '0;
        rd_resp_c   = RESP_SLVERR;
        rd_ro_sel_c = '0;
        for (int unsigned i = 0; i < RW_REGS; i++) begin
            if (rd_idx == IW'(i)) begin
                rd_data_c = rw_q[i];
                rd_resp_c = RESP_OKAY;
            end
        end
        for (int unsigned i = 0; i < RO_REGS; i++) begin
            if (rd_idx == IW'(RO_BASE + i)) begin
                rd_data_c      = ro_regs[32*i +: 32];
                rd_resp_c      = RESP_OKAY;
                rd_ro_sel_c[i] = 1'b1;
            end
        end
    end

    assign axi_arready = ~axi_rvalid;

    always_ff @(posedge clk or negedge aresetb) begin
        if (!aresetb) begin
            axi_rvalid   <= 1'b0;
            axi_rdata    <= '0;
            axi_rresp    <= RESP_OKAY;
            ro_rd_strobe <= '0;
        end else begin
            ro_rd_strobe <= '0;
            if (axi_arvalid && !axi_rvalid) begin
                axi_rvalid   <= 1'b1;
                axi_rdata    <= rd_data_c;
                axi_rresp    <= rd_resp_c;
                ro_rd_strobe <= rd_ro_sel_c;
            end else if (axi_rvalid && axi_rready) begin
                axi_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_regfile.sv
// Directed self-checking bench for ctrl_regfile; expected values are hand-computed.
module tb_ctrl_regfile;

    localparam int unsigned AW = 40;

    logic            clk = 1'b0;
    logic            aresetb;
    logic [AW-1:0]   axi_awaddr;
    logic [2:0]      axi_awprot;
    logic            axi_awvalid;
    logic            axi_awready;
    logic [31:0]     axi_wdata;
    logic [3:0]      axi_wstrb;
    logic            axi_wvalid;
    logic            axi_wready;
    logic [1:0]      axi_bresp;
    logic            axi_bvalid;
    logic            axi_bready;
    logic [AW-1:0]   axi_araddr;
    logic [2:0]      axi_arprot;
    logic            axi_arvalid;
    logic            axi_arready;
    logic [31:0]     axi_rdata;
    logic [1:0]      axi_rresp;
    logic            axi_rvalid;
    logic            axi_rready;
    logic [16*32-1:0] rw_regs;
    logic [15:0]     rw_wr_strobe;
    logic [64*32-1:0] ro_regs;
    logic [63:0]     ro_rd_strobe;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ctrl_regfile dut (
        .clk          (clk),
        .aresetb      (aresetb),
        .axi_awaddr   (axi_awaddr),
        .axi_awprot   (axi_awprot),
        .axi_awvalid  (axi_awvalid),
        .axi_awready  (axi_awready),
        .axi_wdata    (axi_wdata),
        .axi_wstrb    (axi_wstrb),
        .axi_wvalid   (axi_wvalid),
        .axi_wready   (axi_wready),
        .axi_bresp    (axi_bresp),
        .axi_bvalid   (axi_bvalid),
        .axi_bready   (axi_bready),
        .axi_araddr   (axi_araddr),
        .axi_arprot   (axi_arprot),
        .axi_arvalid  (axi_arvalid),
        .axi_arready  (axi_arready),
        .axi_rdata    (axi_rdata),
        .axi_rresp    (axi_rresp),
        .axi_rvalid   (axi_rvalid),
        .axi_rready   (axi_rready),
        .rw_regs      (rw_regs),
        .rw_wr_strobe (rw_wr_strobe),
        .ro_regs      (ro_regs),
        .ro_rd_strobe (ro_rd_strobe)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rw_word(input int idx);
        return rw_regs[32*idx +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_req(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        axi_awaddr  = addr;
        axi_wdata   = data;
        axi_wstrb   = strb;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
    endtask

    task automatic b_ack();
        axi_bready = 1'b1;
        tick();
        axi_bready = 1'b0;
    endtask

    task automatic read_req(input logic [AW-1:0] addr);
        axi_araddr  = addr;
        axi_arvalid = 1'b1;
        tick();
        axi_arvalid = 1'b0;
    endtask

    task automatic r_ack();
        axi_rready = 1'b1;
        tick();
        axi_rready = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_reg2;

        aresetb     = 1'b0;
        axi_awaddr  = '0;
        axi_awprot  = '0;
        axi_awvalid = 1'b0;
        axi_wdata   = '0;
        axi_wstrb   = '0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b0;
        axi_araddr  = '0;
        axi_arprot  = '0;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        ro_regs     = '0;
        for (int i = 0; i < 64; i++) ro_regs[32*i +: 32] = 32'hC000_0000 | 32'(i);
        ro_regs[31:0] = 32'hDEAD_BEEF;
        ro_regs[63*32 +: 32] = 32'h0BAD_F00D;

        repeat (2) @(posedge clk);
        #1;
        check("rst_awready", 64'(axi_awready), 64'd1);
        check("rst_wready",  64'(axi_wready),  64'd1);
        check("rst_arready", 64'(axi_arready), 64'd1);
        check("rst_bvalid",  64'(axi_bvalid),  64'd0);
        check("rst_rvalid",  64'(axi_rvalid),  64'd0);
        check("rst_rdata",   64'(axi_rdata),   64'd0);
        check("rst_rw_zero", 64'(|rw_regs),    64'd0);
        aresetb = 1'b1;
        tick();

        // AW first, W three cycles later, response held under back-pressure
        axi_awaddr  = 40'h4;
        axi_awvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        check("t1_awready_low", 64'(axi_awready), 64'd0);
        tick();
        tick();
        axi_wdata  = 32'h0000_1234;
        axi_wstrb  = 4'hF;
        axi_wvalid = 1'b1;
        tick();
        axi_wvalid = 1'b0;
        check("t1_pre_commit_reg1", 64'(rw_word(1)), 64'd0);
        check("t1_pre_commit_bvalid", 64'(axi_bvalid), 64'd0);
        tick();
        check("t1_reg1", 64'(rw_word(1)), 64'h1234);
        check("t1_strobe", 64'(rw_wr_strobe), 64'h0002);
        check("t1_bvalid", 64'(axi_bvalid), 64'd1);
        check("t1_bresp", 64'(axi_bresp), 64'd0);
        tick();
        check("t1_strobe_clr", 64'(rw_wr_strobe), 64'd0);
        check("t1_bvalid_hold", 64'(axi_bvalid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_bvalid_hold", 64'(axi_bvalid), 64'd1);
        end
        check("t1_awready_hold", 64'(axi_awready), 64'd0);
        b_ack();
        check("t1_bvalid_drop", 64'(axi_bvalid), 64'd0);
        check("t1_awready_back", 64'(axi_awready), 64'd1);
        check("t1_wready_back", 64'(axi_wready), 64'd1);

        // W before AW to register 0; pulse bits self-clear after one cycle
        axi_wdata  = 32'h8000_0007;
        axi_wstrb  = 4'hF;
        axi_wvalid = 1'b1;
        tick();
        axi_wvalid = 1'b0;
        check("t2_wready_low", 64'(axi_wready), 64'd0);
        check("t2_awready_high", 64'(axi_awready), 64'd1);
        axi_awaddr  = 40'h0;
        axi_awvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        tick();
        check("t2_pulse_set", 64'(rw_word(0)), 64'h8000_0007);
        check("t2_strobe", 64'(rw_wr_strobe), 64'h0001);
        tick();
        check("t2_pulse_clr", 64'(rw_word(0)), 64'h8000_0000);
        b_ack();
        check("t2_pulse_stay", 64'(rw_word(0)), 64'h8000_0000);
        read_req(40'h0);
        check("t2_rd_rvalid", 64'(axi_rvalid), 64'd1);
        check("t2_rd_data", 64'(axi_rdata), 64'h8000_0000);
        check("t2_rd_resp", 64'(axi_rresp), 64'd0);
        check("t2_arready_low", 64'(axi_arready), 64'd0);
        r_ack();
        check("t2_rvalid_drop", 64'(axi_rvalid), 64'd0);

        // Read accepted on the commit edge of a write to the same register
        write_req(40'h4, 32'h0000_AAAA, 4'hF);
        axi_araddr  = 40'h4;
        axi_arvalid = 1'b1;
        tick();
        axi_arvalid = 1'b0;
        check("sim_rd_old", 64'(axi_rdata), 64'h1234);
        check("sim_reg1_new", 64'(rw_word(1)), 64'hAAAA);
        axi_bready = 1'b1;
        axi_rready = 1'b1;
        tick();
        axi_bready = 1'b0;
        axi_rready = 1'b0;

        // RO word 0 with read back-pressure; source changes after acceptance
        read_req(40'h200);
        check("t3_rdata", 64'(axi_rdata), 64'hDEAD_BEEF);
        check("t3_rresp", 64'(axi_rresp), 64'd0);
        check("t3_ro_strobe", ro_rd_strobe, 64'h1);
        check("t3_arready_low", 64'(axi_arready), 64'd0);
        ro_regs[31:0] = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_rdata_stable", 64'(axi_rdata), 64'hDEAD_BEEF);
            check("t3_ro_strobe_once", ro_rd_strobe, 64'd0);
            check("t3_arready_hold", 64'(axi_arready), 64'd0);
        end
        r_ack();
        check("t3_rvalid_drop", 64'(axi_rvalid), 64'd0);
        check("t3_arready_back", 64'(axi_arready), 64'd1);

        // RO window edges and unmapped reads
        read_req(40'h2FC);
        check("ro_last_data", 64'(axi_rdata), 64'h0BAD_F00D);
        check("ro_last_strobe", ro_rd_strobe, 64'h8000_0000_0000_0000);
        r_ack();
        read_req(40'h300);
        check("ro_past_resp", 64'(axi_rresp), 64'h2);
        check("ro_past_data", 64'(axi_rdata), 64'd0);
        check("ro_past_strobe", ro_rd_strobe, 64'd0);
        r_ack();
        read_req(40'h40);
        check("gap_resp", 64'(axi_rresp), 64'h2);
        r_ack();
        read_req(40'h3FC);
        check("t4_rd_resp", 64'(axi_rresp), 64'h2);
        check("t4_rd_data", 64'(axi_rdata), 64'd0);
        r_ack();

        // Unmapped and RO-space writes
        write_req(40'h100, 32'hFFFF_FFFF, 4'hF);
        tick();
        check("t4_wr_bvalid", 64'(axi_bvalid), 64'd1);
        check("t4_wr_bresp", 64'(axi_bresp), 64'h2);
        check("t4_wr_strobe", 64'(rw_wr_strobe), 64'd0);
        check("t4_reg0_keep", 64'(rw_word(0)), 64'h8000_0000);
        check("t4_reg1_keep", 64'(rw_word(1)), 64'hAAAA);
        b_ack();
        write_req(40'h200, 32'h5555_5555, 4'hF);
        tick();
        check("ro_wr_bresp", 64'(axi_bresp), 64'h2);
        check("ro_wr_strobe", 64'(rw_wr_strobe), 64'd0);
        b_ack();

        // Last RW register
        write_req(40'h3C, 32'h5A5A_5A5A, 4'hF);
        tick();
        check("rw_last_bresp", 64'(axi_bresp), 64'd0);
        check("rw_last_strobe", 64'(rw_wr_strobe), 64'h8000);
        check("rw_last_data", 64'(rw_word(15)), 64'h5A5A_5A5A);
        b_ack();

        // Byte-lane strobes
        write_req(40'h8, 32'hFFFF_FFFF, 4'hF);
        tick();
        b_ack();
        check("ws_full", 64'(rw_word(2)), 64'hFFFF_FFFF);
        write_req(40'h8, 32'h0000_0000, 4'b0101);
        tick();
`ifdef CTRL_REGFILE_WSTRB_EN
        exp_reg2 = 32'hFF00_FF00;
`else
        exp_reg2 = 32'h0000_0000;
`endif
        check("ws_partial", 64'(rw_word(2)), 64'(exp_reg2));
        check("ws_partial_strobe", 64'(rw_wr_strobe), 64'h0004);
        b_ack();
        write_req(40'h8, 32'h1111_1111, 4'b0000);
        tick();
`ifdef CTRL_REGFILE_WSTRB_EN
        exp_reg2 = 32'hFF00_FF00;
`else
        exp_reg2 = 32'h1111_1111;
`endif
        check("ws_none", 64'(rw_word(2)), 64'(exp_reg2));
        check("ws_none_strobe", 64'(rw_wr_strobe), 64'h0004);
        b_ack();

        // Reset with both responses pending
        write_req(40'h4, 32'h0000_0077, 4'hF);
        tick();
        read_req(40'h4);
        check("rst_mid_bvalid_pre", 64'(axi_bvalid), 64'd1);
        check("rst_mid_rvalid_pre", 64'(axi_rvalid), 64'd1);
        aresetb = 1'b0;
        #1;
        check("rst_mid_bvalid", 64'(axi_bvalid), 64'd0);
        check("rst_mid_rvalid", 64'(axi_rvalid), 64'd0);
        check("rst_mid_rw_zero", 64'(|rw_regs), 64'd0);
        check("rst_mid_awready", 64'(axi_awready), 64'd1);
        tick();
        aresetb = 1'b1;
        tick();
        check("rst_post_bvalid", 64'(axi_bvalid), 64'd0);
        read_req(40'h4);
        check("rst_post_rd_reg1", 64'(axi_rdata), 64'd0);
        r_ack();
        read_req(40'h0);
        check("rst_post_rd_reg0", 64'(axi_rdata), 64'd0);
        r_ack();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
